// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issues one decoded ALU request at a time to the shared ALU,
// waits the per-op latency and returns the result over a valid/ready port.
module alu_issue_ctrl #(
  parameter int WIDTH   = 32,
  parameter int TAGW    = 5,
  parameter int MUL_LAT = 3,
  parameter int DIV_LAT = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [3:0]       req_sel,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  input  logic [TAGW-1:0]  req_tag,
  output logic [3:0]       alu_sel,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_res,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_data,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             rsp_wen,
  output logic             rsp_err,
  output logic             busy
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  localparam logic [3:0] SEL_MUL = 4'b0101;
  localparam logic [3:0] SEL_DIV = 4'b1000;
  localparam logic [3:0] SEL_NOP = 4'b1101;

  localparam int MAX_LAT =
    (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CW = $clog2(MAX_LAT) + 1;

  localparam logic [CW-1:0] CNT_MUL = CW'(MUL_LAT - 1);
  localparam logic [CW-1:0] CNT_DIV = CW'(DIV_LAT - 1);

  logic [1:0]    state;
  logic [CW-1:0] cnt;

  logic          sel_legal;
  logic          byp;
  logic          byp_err;
  logic          byp_ones;
  logic          b_zero;
  logic [CW-1:0] cnt_load;

  logic          accept;
  logic          finish;
  logic          release_rsp;

  assign req_ready = (state == S_IDLE);
  assign busy      = (state != S_IDLE);

  assign accept      = (state == S_IDLE) && req_valid;
  assign finish      = (state == S_EXEC) && (cnt == '0);
  assign release_rsp = (state == S_HOLD) && rsp_ready;

  assign b_zero = (req_b == '0);

  // Classify the incoming selector: legality, bypass kind and latency load.
  always_comb begin
    sel_legal = 1'b0;
    byp       = 1'b0;
    byp_err   = 1'b0;
    byp_ones  = 1'b0;
    cnt_load  = '0;
    case (req_sel)
      4'b0000, 4'b0001, 4'b0010, 4'b0100,
      4'b0101, 4'b0110, 4'b0111, 4'b1000,
      4'b1001, 4'b1011, 4'b1100, 4'b1101:
        sel_legal = 1'b1;
      default:
        sel_legal = 1'b0;
    endcase
    unique case (1'b1)
      !sel_legal: begin
        byp     = 1'b1;
        byp_err = 1'b1;
      end
      (req_sel == SEL_NOP): begin
        byp = 1'b1;
      end
      (req_sel == SEL_DIV) && b_zero: begin
        byp      = 1'b1;
        byp_err  = 1'b1;
        byp_ones = 1'b1;
      end
      (req_sel == SEL_MUL): begin
        cnt_load = CNT_MUL;
      end
      (req_sel == SEL_DIV) && !b_zero: begin
        cnt_load = CNT_DIV;
      end
      default: begin
        cnt_load = '0;
      end
    endcase
  end

  // Control state: bypass ops jump straight to HOLD on the accept edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (req_valid) begin
            state <= byp ? S_HOLD : S_EXEC;
          end
        end
        S_EXEC: begin
          if (cnt == '0) begin
            state <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (rsp_ready) begin
            state <= S_IDLE;
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Latency counter: loaded only on accept, so it never wraps.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      cnt <= cnt_load;
    end else if ((state == S_EXEC) && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  // ALU drive: held stable through EXEC, parked on no-op otherwise.
  always_ff @(posedge clk) begin
    if (reset) begin
      alu_sel <= SEL_NOP;
      alu_a   <= '0;
      alu_b   <= '0;
    end else if (accept) begin
      alu_sel <= byp ? SEL_NOP : req_sel;
      alu_a   <= req_a;
      alu_b   <= req_b;
    end else if (release_rsp) begin
      alu_sel <= SEL_NOP;
    end
  end

  // Response tag is captured on accept for every request kind.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_tag <= '0;
    end else if (accept) begin
      rsp_tag <= req_tag;
    end
  end

  // Response payload and valid: bypass fills it on accept, EXEC on finish.
  always_ff @(posedge clk) begin
    if (reset) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_wen   <= 1'b0;
      rsp_err   <= 1'b0;
    end else if (accept && byp) begin
      rsp_valid <= 1'b1;
      rsp_data  <= byp_ones ? '1 : '0;
      rsp_wen   <= 1'b0;
      rsp_err   <= byp_err;
    end else if (finish) begin
      rsp_valid <= 1'b1;
      rsp_data  <= alu_res;
      rsp_wen   <= 1'b1;
      rsp_err   <= 1'b0;
    end else if (release_rsp) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl: directed and randomized checks of alu_issue_ctrl
// against a behavioural ALU and response model.
module tb_alu_issue_ctrl;

  localparam int WIDTH   = 32;
  localparam int TAGW    = 5;
  localparam int MUL_LAT = 3;
  localparam int DIV_LAT = 8;

  localparam logic [3:0] NOP = 4'b1101;

  logic             clk;
  logic             reset;
  logic             req_valid;
  logic             req_ready;
  logic [3:0]       req_sel;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic [TAGW-1:0]  req_tag;
  logic [3:0]       alu_sel;
  logic [WIDTH-1:0] alu_a;
  logic [WIDTH-1:0] alu_b;
  logic [WIDTH-1:0] alu_res;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_data;
  logic [TAGW-1:0]  rsp_tag;
  logic             rsp_wen;
  logic             rsp_err;
  logic             busy;

  int checks   = 0;
  int failures = 0;

  alu_issue_ctrl #(
    .WIDTH  (WIDTH),
    .TAGW   (TAGW),
    .MUL_LAT(MUL_LAT),
    .DIV_LAT(DIV_LAT)
  ) dut (
    .clk      (clk),
    .reset    (reset),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_sel  (req_sel),
    .req_a    (req_a),
    .req_b    (req_b),
    .req_tag  (req_tag),
    .alu_sel  (alu_sel),
    .alu_a    (alu_a),
    .alu_b    (alu_b),
    .alu_res  (alu_res),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_data (rsp_data),
    .rsp_tag  (rsp_tag),
    .rsp_wen  (rsp_wen),
    .rsp_err  (rsp_err),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural ALU with the same selector encoding.
  function automatic logic [WIDTH-1:0] alu_fn(
    input logic [3:0]       sel,
    input logic [WIDTH-1:0] a,
    input logic [WIDTH-1:0] b
  );
    case (sel)
      4'b0000: return a & b;
      4'b0001: return a | b;
      4'b0010: return a + b;
      4'b0100: return a ^ b;
      4'b0101: return a * b;
      4'b0110: return a - b;
      4'b0111: return ($signed(a) < $signed(b)) ? 1 : 0;
      4'b1000: return (b != 0) ? a / b : '1;
      4'b1001: return (b != 0) ? a % b : a;
      4'b1011: return a << b[4:0];
      4'b1100: return ~(a | b);
      default: return '0;
    endcase
  endfunction

  // Expected response and latency in edges after the accept edge.
  function automatic void ref_model(
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] d,
    output logic             err,
    output logic             wen,
    output int               lat
  );
    bit legal;
    legal = sel inside {4'b0000, 4'b0001, 4'b0010, 4'b0100,
                        4'b0101, 4'b0110, 4'b0111, 4'b1000,
                        4'b1001, 4'b1011, 4'b1100, 4'b1101};
    if (!legal) begin
      d = '0; err = 1'b1; wen = 1'b0; lat = 0;
    end else if (sel == NOP) begin
      d = '0; err = 1'b0; wen = 1'b0; lat = 0;
    end else if (sel == 4'b1000 && b == 0) begin
      d = '1; err = 1'b1; wen = 1'b0; lat = 0;
    end else begin
      d   = alu_fn(sel, a, b);
      err = 1'b0;
      wen = 1'b1;
      lat = (sel == 4'b0101) ? MUL_LAT :
            (sel == 4'b1000) ? DIV_LAT : 1;
    end
  endfunction

  always_comb alu_res = alu_fn(alu_sel, alu_a, alu_b);

  // Drive one request; return edges from accept to rsp_valid and
  // whether the EXEC cycles looked right (busy, not ready, sel held).
  task automatic issue(
    input  logic [3:0]       sel,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [TAGW-1:0]  tag,
    output int               lat,
    output bit               exec_ok
  );
    int n;
    n = 0;
    while (!req_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (req_ready !== 1'b1) begin
      failures++;
      $display("FAIL issue_wait req_ready=%0b required=1", req_ready);
    end
    req_valid = 1'b1;
    req_sel   = sel;
    req_a     = a;
    req_b     = b;
    req_tag   = tag;
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_sel   = 4'($urandom);
    req_a     = $urandom;
    req_b     = $urandom;
    lat       = 0;
    exec_ok   = 1'b1;
    while (!rsp_valid && lat < 100) begin
      if (!busy || req_ready || alu_sel !== sel) exec_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic drop_rsp();
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({req_ready, busy, alu_sel, rsp_valid, rsp_wen, rsp_err}
        !== {1'b1, 1'b0, NOP, 1'b0, 1'b0, 1'b0}) begin
      failures++;
      $display("FAIL reset_ctrl rdy=%0b busy=%0b sel=%b v=%0b wen=%0b err=%0b required 1 0 1101 0 0 0",
               req_ready, busy, alu_sel, rsp_valid, rsp_wen, rsp_err);
    end
    checks++;
    if ({alu_a, alu_b, rsp_data, rsp_tag} !== '0) begin
      failures++;
      $display("FAIL reset_data a=%h b=%h d=%h tag=%h required all 0",
               alu_a, alu_b, rsp_data, rsp_tag);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL reset_idle rdy=%0b busy=%0b v=%0b required 1 0 0",
               req_ready, busy, rsp_valid);
    end
  endtask

  task automatic test_add();
    int lat;
    bit ok;
    issue(4'b0010, 5, 7, 3, lat, ok);
    checks++;
    if (lat !== 1) begin
      failures++;
      $display("FAIL add_lat got=%0d required=1", lat);
    end
    checks++;
    if ({rsp_data, rsp_tag, rsp_wen, rsp_err} !== {32'd12, 5'd3, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL add_rsp d=%0d tag=%0d wen=%0b err=%0b required 12 3 1 0",
               rsp_data, rsp_tag, rsp_wen, rsp_err);
    end
    drop_rsp();
  endtask

  task automatic test_mul();
    int lat;
    bit ok;
    issue(4'b0101, 6, 7, 1, lat, ok);
    checks++;
    if (lat !== MUL_LAT) begin
      failures++;
      $display("FAIL mul_lat got=%0d required=%0d", lat, MUL_LAT);
    end
    checks++;
    if (ok !== 1'b1) begin
      failures++;
      $display("FAIL mul_exec exec_ok=%0b required=1", ok);
    end
    checks++;
    if ({rsp_data, rsp_wen, rsp_err} !== {32'd42, 1'b1, 1'b0}) begin
      failures++;
      $display("FAIL mul_rsp d=%0d wen=%0b err=%0b required 42 1 0",
               rsp_data, rsp_wen, rsp_err);
    end
    drop_rsp();
  endtask

  task automatic test_div();
    int lat;
    bit ok;
    issue(4'b1000, 9, 0, 2, lat, ok);
    checks++;
    if (lat !== 0) begin
      failures++;
      $display("FAIL div0_lat got=%0d required=0", lat);
    end
    checks++;
    if ({rsp_data, rsp_tag, rsp_wen, rsp_err, alu_sel}
        !== {32'hFFFF_FFFF, 5'd2, 1'b0, 1'b1, NOP}) begin
      failures++;
      $display("FAIL div0_rsp d=%h tag=%0d wen=%0b err=%0b sel=%b required ffffffff 2 0 1 1101",
               rsp_data, rsp_tag, rsp_wen, rsp_err, alu_sel);
    end
    drop_rsp();
    issue(4'b1000, 100, 7, 8, lat, ok);
    checks++;
    if (lat !== DIV_LAT) begin
      failures++;
      $display("FAIL div_lat got=%0d required=%0d", lat, DIV_LAT);
    end
    checks++;
    if ({rsp_data, rsp_wen, rsp_err, ok} !== {32'd14, 1'b1, 1'b0, 1'b1}) begin
      failures++;
      $display("FAIL div_rsp d=%0d wen=%0b err=%0b exec_ok=%0b required 14 1 0 1",
               rsp_data, rsp_wen, rsp_err, ok);
    end
    drop_rsp();
  endtask

  task automatic test_illegal_nop();
    int lat;
    bit ok;
    issue(4'b1111, 1, 2, 5, lat, ok);
    checks++;
    if ({rsp_data, rsp_wen, rsp_err, alu_sel} !== {32'd0, 1'b0, 1'b1, NOP}
        || lat !== 0) begin
      failures++;
      $display("FAIL illegal_rsp d=%0d wen=%0b err=%0b sel=%b lat=%0d required 0 0 1 1101 0",
               rsp_data, rsp_wen, rsp_err, alu_sel, lat);
    end
    drop_rsp();
    issue(NOP, 3, 4, 6, lat, ok);
    checks++;
    if ({rsp_data, rsp_tag, rsp_wen, rsp_err} !== {32'd0, 5'd6, 1'b0, 1'b0}
        || lat !== 0) begin
      failures++;
      $display("FAIL nop_rsp d=%0d tag=%0d wen=%0b err=%0b lat=%0d required 0 6 0 0 0",
               rsp_data, rsp_tag, rsp_wen, rsp_err, lat);
    end
    drop_rsp();
  endtask

  task automatic test_back_pressure();
    int lat;
    bit ok;
    issue(4'b0010, 20, 22, 6, lat, ok);
    req_valid = 1'b1;
    req_sel   = 4'b0010;
    req_a     = 1;
    req_b     = 2;
    req_tag   = 9;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if ({rsp_valid, rsp_data, rsp_tag, rsp_wen, busy, req_ready}
          !== {1'b1, 32'd42, 5'd6, 1'b1, 1'b1, 1'b0}) begin
        failures++;
        $display("FAIL bp_hold cyc=%0d v=%0b d=%0d tag=%0d wen=%0b busy=%0b rdy=%0b required 1 42 6 1 1 0",
                 i, rsp_valid, rsp_data, rsp_tag, rsp_wen, busy, req_ready);
      end
    end
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    checks++;
    if ({req_ready, busy, rsp_valid} !== 3'b100) begin
      failures++;
      $display("FAIL bp_release rdy=%0b busy=%0b v=%0b required 1 0 0",
               req_ready, busy, rsp_valid);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({rsp_valid, rsp_data, rsp_tag, rsp_wen} !== {1'b1, 32'd3, 5'd9, 1'b1}) begin
      failures++;
      $display("FAIL bp_second v=%0b d=%0d tag=%0d wen=%0b required 1 3 9 1",
               rsp_valid, rsp_data, rsp_tag, rsp_wen);
    end
    drop_rsp();
  endtask

  task automatic test_reset_mid_div();
    int stale;
    req_valid = 1'b1;
    req_sel   = 4'b1000;
    req_a     = 100;
    req_b     = 7;
    req_tag   = 4;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({busy, alu_sel} !== {1'b1, 4'b1000}) begin
      failures++;
      $display("FAIL rst_div_pre busy=%0b sel=%b required 1 1000", busy, alu_sel);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checks++;
    if ({busy, req_ready, alu_sel, rsp_valid, rsp_tag, alu_a}
        !== {1'b0, 1'b1, NOP, 1'b0, 5'd0, 32'd0}) begin
      failures++;
      $display("FAIL rst_div_post busy=%0b rdy=%0b sel=%b v=%0b tag=%0d a=%0d required 0 1 1101 0 0 0",
               busy, req_ready, alu_sel, rsp_valid, rsp_tag, alu_a);
    end
    stale = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (rsp_valid) stale++;
    end
    checks++;
    if (stale !== 0) begin
      failures++;
      $display("FAIL rst_div_stale cycles_valid=%0d required=0", stale);
    end
  endtask

  task automatic test_random();
    logic [3:0]       sel;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [TAGW-1:0]  tag;
    logic [WIDTH-1:0] ed;
    logic             eerr;
    logic             ewen;
    int               elat;
    int               lat;
    bit               ok;
    int               hold;
    for (int i = 0; i < 150; i++) begin
      sel = 4'($urandom);
      a   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom;
      b   = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 300));
      tag = 5'($urandom);
      ref_model(sel, a, b, ed, eerr, ewen, elat);
      issue(sel, a, b, tag, lat, ok);
      checks++;
      if (lat !== elat || (elat > 0 && ok !== 1'b1)) begin
        failures++;
        $display("FAIL rand_lat n=%0d sel=%b got=%0d exec_ok=%0b required %0d",
                 i, sel, lat, ok, elat);
      end
      checks++;
      if ({rsp_data, rsp_tag, rsp_err, rsp_wen} !== {ed, tag, eerr, ewen}) begin
        failures++;
        $display("FAIL rand_rsp n=%0d sel=%b a=%h b=%h got d=%h tag=%0d err=%0b wen=%0b required d=%h tag=%0d err=%0b wen=%0b",
                 i, sel, a, b, rsp_data, rsp_tag, rsp_err, rsp_wen, ed, tag, eerr, ewen);
      end
      hold = $urandom_range(0, 3);
      for (int k = 0; k < hold; k++) begin
        @(posedge clk); #1;
        checks++;
        if ({rsp_valid, rsp_data, rsp_tag} !== {1'b1, ed, tag}) begin
          failures++;
          $display("FAIL rand_hold n=%0d v=%0b d=%h tag=%0d required 1 %h %0d",
                   i, rsp_valid, rsp_data, rsp_tag, ed, tag);
        end
      end
      drop_rsp();
    end
  endtask

  initial begin
    reset     = 1'b1;
    req_valid = 1'b0;
    req_sel   = 4'b0000;
    req_a     = '0;
    req_b     = '0;
    req_tag   = '0;
    rsp_ready = 1'b0;
    test_reset();
    test_add();
    test_mul();
    test_div();
    test_illegal_nop();
    test_back_pressure();
    test_reset_mid_div();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
